// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory requester feeding a
// small {pc, inst} FIFO, with redirect flush and in-flight response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel_i,
    input  logic [31:0] alu_res_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        inst_valid_o
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = AW + 1;
    localparam logic [AW:0] OCC_FULL = OW'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_LAST = OW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fpc;
    logic [31:0]   r_issue_pc;
    logic [31:0]   r_pc_mem   [FIFO_DEPTH];
    logic [31:0]   r_inst_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;

    logic w_out_q;
    logic w_disc_q;
    logic w_req;
    logic w_grant;
    logic w_push;
    logic w_pop;
    logic w_valid;
    logic w_show;

    // out_q / disc_q are encoded by the FSM: WAIT = live outstanding, DRAIN = outstanding to discard.
    always_comb begin
        w_out_q     = (r_state != S_REQ);
        w_disc_q    = (r_state == S_DRAIN);
        w_valid     = (r_occ != '0);
        w_req       = 1'b0;
        w_state_nxt = r_state;

        if (!rst && !pc_sel_i) begin
            unique case (r_state)
                S_REQ:   w_req = (r_occ < OCC_FULL);
                S_WAIT:  w_req = imem_rvalid_i && (r_occ < OCC_LAST);
                default: w_req = 1'b0;
            endcase
        end
        w_grant = w_req && imem_gnt_i;
        w_push  = w_out_q && !w_disc_q && imem_rvalid_i && !pc_sel_i;
        w_pop   = w_valid && !stall_i && !pc_sel_i;

        unique case (r_state)
            S_REQ: begin
                if (w_grant) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i)  w_state_nxt = w_grant ? S_WAIT : S_REQ;
                else if (pc_sel_i)  w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (imem_rvalid_i) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fpc      <= RESET_PC;
            r_issue_pc <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (pc_sel_i) begin
                r_fpc  <= alu_res_i & 32'hFFFF_FFFC;
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
            end else begin
                if (w_grant) begin
                    r_fpc      <= r_fpc + 32'd4;
                    r_issue_pc <= r_fpc;
                end
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
                else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_issue_pc;
            r_inst_mem[r_wptr] <= imem_rdata_i;
        end
    end

    always_comb begin
        w_show       = w_valid && !pc_sel_i && !rst;
        inst_valid_o = w_show;
        inst_o       = w_show ? r_inst_mem[r_rptr] : '0;
        pc_o         = w_show ? r_pc_mem[r_rptr] : '0;
        pc4_o        = w_show ? (r_pc_mem[r_rptr] + 32'd4) : '0;
        imem_req_o   = w_req;
        imem_addr_o  = rst ? '0 : r_fpc;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; a power of 2, at least 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  main clock; the only clock, all state on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_sel_i  in  1  redirect request from control logic.
- alu_res_i  in  32  redirect target (branch/jump target from the ALU).
- stall_i  in  1  downstream hold; the head instruction is not consumed.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- inst_o  out  32  instruction to control logic; 32'h0000_0000 (NOP) when invalid.
- pc_o  out  32  PC of inst_o; 0 when invalid.
- pc4_o  out  32  pc_o + 4, mod 2^32; 0 when invalid.
- inst_valid_o  out  1  inst_o holds a fetched instruction.

Function
REQ-003 The block SHALL hold a fetch PC register (fpc), a FIFO of {pc, inst} pairs, an outstanding flag (out_q) and a discard flag (disc_q); at most one memory request is outstanding.
REQ-004 The FSM SHALL have three states: REQ, WAIT and DRAIN.
- REQ: imem_req_o = 1 when occ + out_q < FIFO_DEPTH and pc_sel_i = 0.
- REQ -> WAIT on imem_req_o && imem_gnt_i.
- WAIT -> REQ on imem_rvalid_i.
- WAIT -> DRAIN on pc_sel_i without rvalid.
- DRAIN -> REQ on imem_rvalid_i.
REQ-005 imem_addr_o SHALL equal fpc, and imem_addr_o SHALL be stable while imem_req_o = 1 and imem_gnt_i = 0.
REQ-006 On a grant, fpc SHALL advance by 4, mod 2^32, and the issued PC SHALL be captured with the request.
REQ-007 In WAIT, a new request MAY be raised in the same cycle imem_rvalid_i arrives, subject to REQ-004. With a 1-cycle memory and no stall this gives a sustained throughput of 1 instruction per cycle.
REQ-008 A response in WAIT with disc_q = 0 and pc_sel_i = 0 SHALL be pushed to the FIFO and becomes visible on inst_o the next cycle (grant-to-output latency 2 cycles with 1-cycle memory).
REQ-009 inst_o, pc_o, pc4_o and inst_valid_o SHALL show the FIFO head. When the FIFO is empty they SHALL be 0.
REQ-010 The head SHALL be popped at the clock edge when inst_valid_o = 1, stall_i = 0 and pc_sel_i = 0. While stall_i = 1 all four outputs SHALL hold.
REQ-011 A push and a pop in the same cycle SHALL leave occupancy unchanged. The pointers SHALL wrap modulo FIFO_DEPTH, and a full FIFO SHALL never be written (guaranteed by REQ-004).
REQ-012 Redirect (pc_sel_i = 1) in cycle N SHALL cause all of the following:
- imem_req_o = 0, inst_o = 0 and inst_valid_o = 0 in cycle N.
- The FIFO is flushed and fpc = {alu_res_i[31:2], 2'b00} at edge N.
- Any granted, unreturned request is marked disc_q = 1, and its response is dropped.
- A response arriving in cycle N is dropped.
- The first request to the new target is issued in cycle N+1, or once DRAIN completes.
REQ-013 pc_sel_i SHALL take priority over stall_i, and stall_i SHALL NOT block a redirect.
REQ-014 Back-to-back redirects SHALL each take effect, with the last target winning. No more than one response is discarded per outstanding request.
REQ-015 imem_rvalid_i while out_q = 0 SHALL be ignored.

Reset
REQ-016 While rst = 1 the block SHALL hold the following reset values:
- fpc = RESET_PC; FIFO empty; out_q = 0; disc_q = 0; FSM in REQ.
- All outputs 0; imem_req_o = 0.
- imem_rvalid_i ignored.
REQ-017 Reset asserted mid-operation SHALL abandon any outstanding request; the instruction memory shares rst.
REQ-018 imem_req_o SHALL assert with imem_addr_o = RESET_PC in the first cycle after rst falls.

Verification
REQ-019 Reset release, 1-cycle memory, no stall -> inst_o carries the words at 0x0, 0x4, 0x8 on consecutive cycles starting 2 cycles after the first grant; pc4_o = 0x4, 0x8, 0xC.
REQ-020 stall_i = 1 for 5 cycles while streaming -> inst_o and pc_o frozen, occupancy reaches 4, imem_req_o = 0 once occ + out_q = 4, no instruction lost or duplicated after release.
REQ-021 pc_sel_i = 1 with alu_res_i = 0x0000_0103 while a request is outstanding -> the in-flight response is dropped, inst_valid_o = 0 during the redirect cycle, next fetch address 0x0000_0100, first valid pc_o = 0x100.
REQ-022 Redirect while stall_i = 1 with a full FIFO -> FIFO flushed, new target fetched, no stale instruction appears.
REQ-023 rst asserted while in WAIT, memory returns rvalid during rst -> response ignored, first post-reset request address RESET_PC, inst_o = 0 until the new fetch returns.
REQ-024 fpc = 0xFFFF_FFFC fetched -> pc4_o = 0x0000_0000 and the next request address is 0x0000_0000.
